// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding, default geometry and memory rw encoding.
package program_loader_pkg;

  localparam int PL_ADDR_W    = 12;
  localparam int PL_DATA_W    = 16;
  localparam int PL_MEM_WORDS = 32;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    RECV_HI,
    RECV_LO,
    WRITE,
    CHK_HI,
    CHK_LO,
    CHECK,
    RUN,
    ERROR
  } state_e;

  function automatic logic is_rx_state(input state_e s);
    return (s == RECV_HI) || (s == RECV_LO) || (s == CHK_HI) || (s == CHK_LO);
  endfunction

endpackage

// File: rtl/program_loader_byte_pack.sv
// Shifts stream bytes (high byte first) into a word; a byte moves when en_i && byte_valid_i.
// One byte per cycle, word valid the cycle after its last byte; stalls while byte_valid_i is low.
module program_loader_byte_pack #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              take_o,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] word_q;

  assign take_o = en_i & byte_valid_i;
  assign word_o = word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (take_o) begin
      word_q <= {word_q[DATA_W-9:0], byte_i};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program image into memory, checks its checksum, then hands the bus to the CPU.
// One word per 3 cycles at best; byte_ready drops outside receive states, byte_valid low stalls forever.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = PL_ADDR_W,
  parameter int DATA_W    = PL_DATA_W,
  parameter int MEM_WORDS = PL_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic [ADDR_W-1:0] cpu_out_address,
  input  logic              cpu_memrq,
  input  logic              cpu_rnw,
  output logic [DATA_W-1:0] mem_in_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_memrq,
  output logic              mem_rw,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] sum_q;
  logic              byte_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              cpu_rst_n_q;

  logic              take;
  logic [DATA_W-1:0] word;
  logic              len_bad;
  logic              last_word;
  logic              start_ok;

  program_loader_byte_pack #(.DATA_W(DATA_W)) u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (byte_ready_q),
    .byte_i       (byte_in),
    .byte_valid_i (byte_valid),
    .take_o       (take),
    .word_o       (word)
  );

  assign len_bad   = (load_len == '0) || (load_len > ADDR_W'(MEM_WORDS));
  assign last_word = (cnt_q == len_q - ADDR_W'(1));
  assign start_ok  = ((state_q == IDLE) || (state_q == ERROR)) && load_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERROR: if (load_start) state_d = len_bad ? ERROR : RECV_HI;
      RECV_HI:     if (take) state_d = RECV_LO;
      RECV_LO:     if (take) state_d = WRITE;
      WRITE:       state_d = last_word ? CHK_HI : RECV_HI;
      CHK_HI:      if (take) state_d = CHK_LO;
      CHK_LO:      if (take) state_d = CHECK;
      CHECK:       state_d = (word == sum_q) ? RUN : ERROR;
      RUN:         state_d = RUN;
      default:     state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= is_rx_state(state_d);
      busy_q       <= is_rx_state(state_d) || (state_d == WRITE) || (state_d == CHECK);
      done_q       <= (state_d == RUN);
      error_q      <= (state_d == ERROR);
      cpu_rst_n_q  <= (state_q == RUN);
      if (start_ok) begin
        len_q <= load_len;
        cnt_q <= '0;
        sum_q <= '0;
      end
      if (state_q == WRITE) begin
        sum_q <= sum_q + word;
        // Hold on the final word so the address never runs past the image.
        if (!last_word) cnt_q <= cnt_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    mem_memrq   = 1'b0;
    mem_rw      = RW_READ;
    mem_addr    = '0;
    mem_in_data = '0;
    if (state_q == RUN) begin
      mem_memrq   = cpu_memrq;
      mem_rw      = cpu_rnw;
      mem_addr    = cpu_out_address;
      mem_in_data = cpu_out_data;
    end else if (state_q == WRITE) begin
      mem_memrq   = 1'b1;
      mem_rw      = RW_WRITE;
      mem_addr    = cnt_q;
      mem_in_data = word;
    end
  end

  assign byte_ready = byte_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_rst_n  = cpu_rst_n_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboarded memory writes, per-cycle bus rules, timed status checks.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [11:0] load_len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] cpu_out_data;
  logic [11:0] cpu_out_address;
  logic        cpu_memrq;
  logic        cpu_rnw;
  logic [15:0] mem_in_data;
  logic [11:0] mem_addr;
  logic        mem_memrq;
  logic        mem_rw;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  program_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_start      (load_start),
    .load_len        (load_len),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .cpu_out_data    (cpu_out_data),
    .cpu_out_address (cpu_out_address),
    .cpu_memrq       (cpu_memrq),
    .cpu_rnw         (cpu_rnw),
    .mem_in_data     (mem_in_data),
    .mem_addr        (mem_addr),
    .mem_memrq       (mem_memrq),
    .mem_rw          (mem_rw),
    .cpu_rst_n       (cpu_rst_n),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;
  wr_t         exp_q[$];
  logic [15:0] img      [32];
  logic [15:0] mem_model[32];
  int          wr_cnt;
  int          last_addr;
  logic        prev_done;
  logic        prev_wr;

  localparam logic [15:0] PROG21 [21] = '{
    16'h0013, 16'h1012, 16'h1011, 16'h3010, 16'h6006, 16'h7000, 16'h0011,
    16'h2014, 16'h1011, 16'h2012, 16'h1012, 16'h0011, 16'h3010, 16'h6006,
    16'h7000, 16'h0000, 16'h0015, 16'h0000, 16'h0000, 16'h000F, 16'h0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] img_sum(input int len);
    logic [15:0] s = 16'h0;
    for (int i = 0; i < len; i++) s = s + img[i];
    return s;
  endfunction

  // Bus-level rules checked every cycle, plus the expected-write scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_rst_n_follows_run", 32'(cpu_rst_n), 32'(prev_done && done));
      chk("done_error_excl", 32'(done && error), 32'h0);
      if (done) begin
        chk("passthrough", 32'({mem_memrq, mem_rw, mem_addr}), 32'({cpu_memrq, cpu_rnw, cpu_out_address}));
        chk("passthrough_data", 32'(mem_in_data), 32'(cpu_out_data));
      end else if (mem_memrq) begin
        chk("wr_rw", 32'(mem_rw), 32'h0);
        chk("rdy_low_in_write", 32'(byte_ready), 32'h0);
        chk("memrq_single_pulse", 32'(prev_wr), 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e.a));
          chk("write_data", 32'(mem_in_data), 32'(e.d));
        end
        if (mem_addr < 12'd32) mem_model[mem_addr[4:0]] = mem_in_data;
        wr_cnt++;
        last_addr = int'(mem_addr);
      end else begin
        chk("idle_bus", 32'({mem_rw, mem_addr, mem_in_data}), 32'({1'b1, 12'h0, 16'h0}));
      end
      prev_wr = !done && mem_memrq;
    end
    prev_done = done;
  end

  task automatic do_reset();
    rst_n = 1'b0; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_in = '0;
    cpu_out_data = '0; cpu_out_address = '0; cpu_memrq = 1'b0; cpu_rnw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
    last_addr = -1;
    for (int i = 0; i < 32; i++) mem_model[i] = 16'hDEAD;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_status"}, 32'({byte_ready, busy, done, error, cpu_rst_n}), 32'h0);
    chk({tag, "_bus"}, 32'({mem_memrq, mem_rw, mem_addr, mem_in_data}), 32'({1'b0, 1'b1, 12'h0, 16'h0}));
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = 12'(len);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    load_len   = $urandom_range(0, 4095);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit acc;
    int n = 0;
    if (stall) begin
      repeat (int'($urandom_range(0, 3))) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    byte_valid = 1'b1;
    byte_in    = b;
    forever begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("byte_accept_timeout", 32'h0, 32'h1);
        break;
      end
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic send_data_word(input int i, input bit stall, input bit poke_start);
    exp_q.push_back('{a: 12'(i), d: img[i]});
    send_byte(img[i][15:8], stall);
    if (poke_start) begin
      load_start = 1'b1;
      load_len   = 12'd0;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      chk("ignored_start_busy", 32'({busy, error}), 32'({1'b1, 1'b0}));
    end
    send_byte(img[i][7:0], stall);
  endtask

  task automatic finish_load(input logic [15:0] cks, input bit stall, input bit exp_ok);
    send_byte(cks[15:8], stall);
    send_byte(cks[7:0], stall);
    chk("check_cycle_status", 32'({byte_ready, busy, done}), 32'({1'b0, 1'b1, 1'b0}));
    @(posedge clk);
    #1;
    chk("result_status", 32'({busy, done, error, cpu_rst_n}), 32'({1'b0, exp_ok, !exp_ok, 1'b0}));
    @(posedge clk);
    #1;
    chk("cpu_rst_n_late", 32'(cpu_rst_n), 32'(exp_ok));
    chk("writes_all_seen", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic load_img(input int len, input logic [15:0] cks, input bit stall,
                          input int poke_word, input bit exp_ok);
    start_load(len);
    chk("start_status", 32'({busy, error, byte_ready}), 32'({1'b1, 1'b0, 1'b1}));
    for (int i = 0; i < len; i++) send_data_word(i, stall, i == poke_word);
    finish_load(cks, stall, exp_ok);
    chk("write_count", 32'(wr_cnt), 32'(len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_done = 1'b0;
    prev_wr   = 1'b0;
    do_reset();
    check_reset_outputs("reset");
    chk_en = 1;

    for (int i = 0; i < 21; i++) img[i] = PROG21[i];
    chk("model_sum21", 32'(img_sum(21)), 32'h80F2);

    // Full 21-word load, no stalls.
    load_img(21, 16'h80F2, 0, -1, 1);
    for (int i = 0; i < 21; i++) chk("mem_image", 32'(mem_model[i]), 32'(img[i]));
    chk("mem0_literal", 32'(mem_model[0]), 32'h0013);
    chk("mem20_literal", 32'(mem_model[20]), 32'h0001);
    chk("last_addr21", 32'(last_addr), 32'd20);
    cpu_out_data = 16'hBEEF; cpu_out_address = 12'h012; cpu_memrq = 1'b1; cpu_rnw = 1'b0;
    @(negedge clk);
    chk("run_bus_literal", 32'({mem_memrq, mem_rw, mem_addr, mem_in_data}), 32'({1'b1, 1'b0, 12'h012, 16'hBEEF}));
    @(posedge clk);
    #1;
    start_load(3);
    chk("run_ignores_start", 32'({busy, done, error, cpu_rst_n}), 32'({1'b0, 1'b1, 1'b0, 1'b1}));

    // Bad checksum with random stalls.
    do_reset();
    load_img(21, 16'h80F3, 1, -1, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("error_hold", 32'({error, cpu_rst_n, mem_memrq}), 32'({1'b1, 1'b0, 1'b0}));
    end

    // Length bounds, then retry from ERROR with a full 32-word image.
    do_reset();
    start_load(0);
    chk("len0_error", 32'({error, busy, byte_ready}), 32'({1'b1, 1'b0, 1'b0}));
    start_load(33);
    chk("len33_error", 32'({error, busy}), 32'({1'b1, 1'b0}));
    for (int i = 0; i < 32; i++) img[i] = 16'($urandom);
    load_img(32, img_sum(32), 1, -1, 1);
    chk("last_addr32", 32'(last_addr), 32'd31);

    // load_start during RECV_LO is ignored.
    do_reset();
    for (int i = 0; i < 21; i++) img[i] = PROG21[i];
    load_img(21, 16'h80F2, 0, 2, 1);

    // Reset after 5 words, then a fresh 3-word load.
    do_reset();
    start_load(21);
    for (int i = 0; i < 5; i++) send_data_word(i, 1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midload_reset");
    chk("midload_writes", 32'(wr_cnt), 32'd5);
    rst_n = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
    img[0] = 16'h1234; img[1] = 16'hF00D; img[2] = 16'h0F0F;
    chk("model_sum3", 32'(img_sum(3)), 32'h1150);
    load_img(3, 16'h1150, 1, -1, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
